// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and load/store.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise load/store wins ties.
module mem_arbiter #(
  parameter int M_WIDTH    = 8,
  parameter int INST_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [M_WIDTH-1:0]    if_addr,
  output logic [INST_WIDTH-1:0] if_data,
  output logic                  if_ready,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [M_WIDTH-1:0]    ls_addr,
  input  logic [M_WIDTH-1:0]    ls_wdata,
  output logic [M_WIDTH-1:0]    ls_rdata,
  output logic                  ls_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [M_WIDTH-1:0]    mem_addr,
  output logic [M_WIDTH-1:0]    mem_data_out,
  input  logic [INST_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ready,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_LS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;
  logic   ls_wins;
  logic   if_done;
  logic   ls_done;

  assign if_done = (state == GNT_IF) && mem_ready;
  assign ls_done = (state == GNT_LS) && mem_ready;

`ifdef MEM_ARB_RR_EN
  // Last-served pointer; reset value "fetch" makes load/store win the first tie.
  logic last_ls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ls <= 1'b0;
    end else if (ls_done) begin
      last_ls <= 1'b1;
    end else if (if_done) begin
      last_ls <= 1'b0;
    end
  end

  assign ls_wins = !last_ls;
`else
  assign ls_wins = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Ready flops are high exactly during DONE, so they also identify the owner there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_ready <= 1'b0;
      ls_ready <= 1'b0;
    end else begin
      if_ready <= if_done;
      ls_ready <= ls_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_data  <= '0;
      ls_rdata <= '0;
    end else begin
      if (if_done) begin
        if_data <= mem_data_in;
      end
      if (ls_done && !ls_we) begin
        ls_rdata <= mem_data_in[M_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    next_state   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    grant        = 2'b00;
    case (state)
      IDLE: begin
        if (if_req && ls_req) begin
          next_state = ls_wins ? GNT_LS : GNT_IF;
        end else if (ls_req) begin
          next_state = GNT_LS;
        end else if (if_req) begin
          next_state = GNT_IF;
        end
      end
      GNT_IF: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
        grant    = 2'b01;
        if (mem_ready) begin
          next_state = DONE;
        end
      end
      GNT_LS: begin
        mem_req      = 1'b1;
        mem_we       = ls_we;
        mem_addr     = ls_addr;
        mem_data_out = ls_wdata;
        grant        = 2'b10;
        if (mem_ready) begin
          next_state = DONE;
        end
      end
      DONE: begin
        grant      = {ls_ready, if_ready};
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule
